// File: rtl/reg_display_scan.sv
// Register scan and 8-digit multiplexed seven-segment debug display.
// Optional macro DISP_INDEX_EN: digits 7..6 show the register index, 5..0 show snap[23:0].
module reg_display_scan #(
    parameter int CLK_DIV  = 50000,
    parameter int STEP_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hold,
    input  logic        step,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int DIV_W  = (CLK_DIV  > 2) ? $clog2(CLK_DIV)  : 1;
    localparam int STEP_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

    // Active-low hex glyphs, segment order g..a.
    function automatic logic [6:0] hex_glyph(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            4'hF:    glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
        return glyph;
    endfunction

    logic [DIV_W-1:0]  div_cnt_r;
    logic [STEP_W-1:0] step_cnt_r;
    logic [2:0]        dig_r;
    logic              step_q_r;
    logic [4:0]        sel_r;
    logic              sel_chg_r;
    logic [31:0]       snap_r;
    logic [7:0]        an_r;
    logic [7:0]        seg_r;

    logic              div_wrap_s;
    logic              step_wrap_s;
    logic              auto_step_s;
    logic              man_step_s;
    logic              advance_s;
    logic              snap_en_s;
    logic [31:0]       disp_word_s;
    logic [3:0]        nibble_s;
    logic [7:0]        an_next_s;
    logic              dp_s;

    assign reg_sel = sel_r;
    assign an      = an_r;
    assign seg     = seg_r;

    // Step sources: auto step only while running, manual step only while held,
    // so the two can never request an increment on the same edge.
    always_comb begin
        div_wrap_s  = (div_cnt_r == DIV_LAST);
        step_wrap_s = (step_cnt_r == STEP_LAST);
        auto_step_s = step_wrap_s && !hold;
        man_step_s  = hold && step && !step_q_r;
        advance_s   = auto_step_s || man_step_s;
        snap_en_s   = (step_cnt_r == {STEP_W{1'b0}}) || sel_chg_r;
    end

    // Word presented on the display, with the optional index overlay.
    always_comb begin
`ifdef DISP_INDEX_EN
        disp_word_s = {3'b000, sel_r, snap_r[23:0]};
`else
        disp_word_s = snap_r;
`endif
    end

    // Digit nibble, one-cold anode pattern and decimal point for the current slot.
    always_comb begin
        case (dig_r)
            3'd0:    begin nibble_s = disp_word_s[3:0];   an_next_s = 8'hFE; end
            3'd1:    begin nibble_s = disp_word_s[7:4];   an_next_s = 8'hFD; end
            3'd2:    begin nibble_s = disp_word_s[11:8];  an_next_s = 8'hFB; end
            3'd3:    begin nibble_s = disp_word_s[15:12]; an_next_s = 8'hF7; end
            3'd4:    begin nibble_s = disp_word_s[19:16]; an_next_s = 8'hEF; end
            3'd5:    begin nibble_s = disp_word_s[23:20]; an_next_s = 8'hDF; end
            3'd6:    begin nibble_s = disp_word_s[27:24]; an_next_s = 8'hBF; end
            3'd7:    begin nibble_s = disp_word_s[31:28]; an_next_s = 8'h7F; end
            default: begin nibble_s = 4'h0;               an_next_s = 8'hFF; end
        endcase
        if (hold && (dig_r == 3'd7)) begin
            dp_s = 1'b0;
        end else begin
            dp_s = 1'b1;
        end
    end

    // Refresh divider and digit slot counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_r <= {DIV_W{1'b0}};
            dig_r     <= 3'd0;
        end else if (div_wrap_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            dig_r     <= dig_r + 3'd1;
        end else begin
            div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Free-running step period counter; hold never disturbs its phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step_cnt_r <= {STEP_W{1'b0}};
        end else if (step_wrap_s) begin
            step_cnt_r <= {STEP_W{1'b0}};
        end else begin
            step_cnt_r <= step_cnt_r + {{(STEP_W-1){1'b0}}, 1'b1};
        end
    end

    // Register index, change flag and manual step edge detector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_r     <= 5'd0;
            sel_chg_r <= 1'b0;
            step_q_r  <= 1'b0;
        end else begin
            step_q_r  <= step;
            sel_chg_r <= advance_s;
            if (advance_s) begin
                sel_r <= sel_r + 5'd1;
            end else begin
                sel_r <= sel_r;
            end
        end
    end

    // Snapshot taken once reg_sel has been stable for a cycle, plus periodic refresh.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_r <= 32'h0000_0000;
        end else if (snap_en_s) begin
            snap_r <= reg_data;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Registered display drive; anode and segments update on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an_r  <= 8'hFF;
            seg_r <= 8'hFF;
        end else begin
            an_r  <= an_next_s;
            seg_r <= {dp_s, hex_glyph(nibble_s)};
        end
    end

endmodule
